sim_video_top: RTL and testbench

//  Parametrised Verilator/SDL simulation top. Generates its own display timing and one of four

---
 rtl/sim_video_pkg.sv | 40 ++++
 rtl/sim_display_timing.sv | 65 ++++++
 rtl/sim_video_top.sv | 154 +++++++++++++++
 tb/tb_sim_video_top.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_video_pkg.sv
// ----------------------------------------------------------------------------
// sim_video_pkg : shared pattern types, pattern constants and bar colour helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sim_video_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_GRAD  = 2'd2,
      PAT_GRID  = 2'd3
   } pat_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;

   localparam int BAR_COUNT = 8;
   localparam int CHECK_BIT = 4;
   localparam int GRID_BITS = 5;

   localparam rgb8_t RGB_WHITE = 24'hFF_FF_FF;
   localparam rgb8_t RGB_BLACK = 24'h00_00_00;
   localparam rgb8_t RGB_BLUE  = 24'h00_00_FF;

   function automatic rgb8_t bar_rgb(input logic [2:0] idx);
      rgb8_t c;
      c.r = {8{idx[2]}};
      c.g = {8{idx[1]}};
      c.b = {8{idx[0]}};
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sim_display_timing.sv
// ----------------------------------------------------------------------------
// sim_display_timing : raster position counters with blanking/sync decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sim_display_timing #(
   parameter int CORDW  = 10,
   parameter int H_RES  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_RES  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   output logic [CORDW-1:0] sx_o,
   output logic [CORDW-1:0] sy_o,
   output logic             de_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             eof_o
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   logic [CORDW-1:0] sx_q, sx_d;
   logic [CORDW-1:0] sy_q, sy_d;
   logic             w_line_end;

   assign w_line_end = (sx_q == CORDW'(H_TOTAL - 1));
   assign eof_o      = w_line_end && (sy_q == CORDW'(V_TOTAL - 1));

   always_comb begin
      sx_d = sx_q + 1'b1;
      sy_d = sy_q;
      if (w_line_end) begin
         sx_d = '0;
         sy_d = (sy_q == CORDW'(V_TOTAL - 1)) ? '0 : sy_q + 1'b1;
      end
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         sx_q <= '0;
         sy_q <= '0;
      end else begin
         sx_q <= sx_d;
         sy_q <= sy_d;
      end
   end

   assign sx_o    = sx_q;
   assign sy_o    = sy_q;
   assign de_o    = (sx_q < CORDW'(H_RES)) && (sy_q < CORDW'(V_RES));
   assign hsync_o = (sx_q >= CORDW'(H_RES + H_FP)) && (sx_q < CORDW'(H_RES + H_FP + H_SYNC));
   assign vsync_o = (sy_q >= CORDW'(V_RES + V_FP)) && (sy_q < CORDW'(V_RES + V_FP + V_SYNC));

endmodule

`default_nettype wire

// File: rtl/sim_video_top.sv
// ----------------------------------------------------------------------------
// sim_video_top : self-timed test-pattern source driving the SDL sim harness
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sim_video_top
   import sim_video_pkg::*;
#(
   parameter int CORDW  = 10,
   parameter int CHANW  = 8,
   parameter int H_RES  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_RES  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int PIPE   = 2
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   input  logic [1:0]       mode,
   input  logic             freeze,
   output logic [CORDW-1:0] sdl_sx,
   output logic [CORDW-1:0] sdl_sy,
   output logic             sdl_de,
   output logic             sdl_hsync,
   output logic             sdl_vsync,
   output logic [CHANW-1:0] sdl_r,
   output logic [CHANW-1:0] sdl_g,
   output logic [CHANW-1:0] sdl_b,
   output logic             frame,
   output logic [15:0]      frame_cnt
);

   typedef struct packed {
      logic [CORDW-1:0] sx;
      logic [CORDW-1:0] sy;
      logic             de;
      logic             hsync;
      logic             vsync;
      logic [CHANW-1:0] r;
      logic [CHANW-1:0] g;
      logic [CHANW-1:0] b;
      logic             frame;
   } pixel_t;

   localparam int BAR_W = H_RES / BAR_COUNT;
   localparam int REPS  = CHANW / 8;
   localparam int REM   = CHANW % 8;

   logic [CORDW-1:0] w_sx, w_sy;
   logic             w_de, w_hsync, w_vsync, w_eof;

   sim_display_timing #(
      .CORDW (CORDW),
      .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .sx_o      (w_sx),
      .sy_o      (w_sy),
      .de_o      (w_de),
      .hsync_o   (w_hsync),
      .vsync_o   (w_vsync),
      .eof_o     (w_eof)
   );

   // Mode and count only move on the frame boundary so a frame is never mixed.
   pat_t        mode_q;
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         mode_q      <= PAT_BARS;
         frame_cnt_q <= '0;
      end else if (w_eof) begin
         mode_q <= pat_t'(mode);
         if (!freeze) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   logic [2:0] w_bar_idx;
   rgb8_t      w_rgb8;

   assign w_bar_idx = 3'(w_sx / CORDW'(BAR_W));

   always_comb begin
      w_rgb8 = RGB_BLACK;
      if (w_de) begin
         case (mode_q)
            PAT_BARS:  w_rgb8 = bar_rgb(w_bar_idx);
            PAT_CHECK: w_rgb8 = (w_sx[CHECK_BIT] ^ w_sy[CHECK_BIT]) ? RGB_WHITE : RGB_BLACK;
            PAT_GRAD:  w_rgb8 = {w_sx[7:0], w_sy[7:0], frame_cnt_q[7:0]};
            PAT_GRID:  w_rgb8 = ((w_sx[GRID_BITS-1:0] == '0) || (w_sy[GRID_BITS-1:0] == '0))
                                ? RGB_WHITE : RGB_BLUE;
            default:   w_rgb8 = RGB_BLACK;
         endcase
      end
   end

   logic [CHANW-1:0] w_r, w_g, w_b;

   // Replicate MSB-first so full-scale 8-bit values stay full-scale when widened.
   generate
      if (REM == 0) begin : g_widen_exact
         assign w_r = {REPS{w_rgb8.r}};
         assign w_g = {REPS{w_rgb8.g}};
         assign w_b = {REPS{w_rgb8.b}};
      end else begin : g_widen_rem
         assign w_r = {{REPS{w_rgb8.r}}, w_rgb8.r[7 -: REM]};
         assign w_g = {{REPS{w_rgb8.g}}, w_rgb8.g[7 -: REM]};
         assign w_b = {{REPS{w_rgb8.b}}, w_rgb8.b[7 -: REM]};
      end
   endgenerate

   pixel_t w_stage0;
   pixel_t pipe_q [PIPE];

   assign w_stage0 = {w_sx, w_sy, w_de, w_hsync, w_vsync, w_r, w_g, w_b,
                      (w_sx == '0) && (w_sy == '0)};

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         for (int k = 0; k < PIPE; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pipe_q[0] <= w_stage0;
         for (int k = 1; k < PIPE; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   assign sdl_sx    = pipe_q[PIPE-1].sx;
   assign sdl_sy    = pipe_q[PIPE-1].sy;
   assign sdl_de    = pipe_q[PIPE-1].de;
   assign sdl_hsync = pipe_q[PIPE-1].hsync;
   assign sdl_vsync = pipe_q[PIPE-1].vsync;
   assign sdl_r     = pipe_q[PIPE-1].r;
   assign sdl_g     = pipe_q[PIPE-1].g;
   assign sdl_b     = pipe_q[PIPE-1].b;
   assign frame     = pipe_q[PIPE-1].frame;
   assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_video_top.sv
// ----------------------------------------------------------------------------
// tb_sim_video_top : scoreboarded bench for sim_video_top on a reduced raster
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sim_video_top;

   localparam int CORDW   = 10;
   localparam int PIPE    = 2;
   localparam int H_TOTAL = 24;
   localparam int V_TOTAL = 12;

   logic             clk_pix   = 1'b0;
   logic             rst_pix_n = 1'b0;
   logic [1:0]       mode      = 2'd0;
   logic [1:0]       mode_w    = 2'd2;
   logic             freeze    = 1'b0;

   logic [CORDW-1:0] sdl_sx, sdl_sy;
   logic             sdl_de, sdl_hsync, sdl_vsync, sdl_frame;
   logic [7:0]       sdl_r, sdl_g, sdl_b;
   logic [15:0]      frame_cnt;

   logic [CORDW-1:0] w_sx, w_sy;
   logic             w_de, w_hsync, w_vsync, w_frame;
   logic [11:0]      w_r, w_g, w_b;
   logic [15:0]      w_frame_cnt;

   always #5 clk_pix = ~clk_pix;

   sim_video_top #(
      .CORDW(CORDW), .CHANW(8),
      .H_RES(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_RES(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
      .PIPE(PIPE)
   ) dut (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode), .freeze(freeze),
      .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
      .sdl_hsync(sdl_hsync), .sdl_vsync(sdl_vsync),
      .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b),
      .frame(sdl_frame), .frame_cnt(frame_cnt)
   );

   sim_video_top #(
      .CORDW(CORDW), .CHANW(12),
      .H_RES(256), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_RES(8),   .V_FP(1), .V_SYNC(1), .V_BP(2),
      .PIPE(PIPE)
   ) dut_w (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode_w), .freeze(1'b0),
      .sdl_sx(w_sx), .sdl_sy(w_sy), .sdl_de(w_de),
      .sdl_hsync(w_hsync), .sdl_vsync(w_vsync),
      .sdl_r(w_r), .sdl_g(w_g), .sdl_b(w_b),
      .frame(w_frame), .frame_cnt(w_frame_cnt)
   );

   typedef struct packed {
      logic [CORDW-1:0] sx;
      logic [CORDW-1:0] sy;
      logic             de;
      logic             hsync;
      logic             vsync;
      logic [7:0]       r;
      logic [7:0]       g;
      logic [7:0]       b;
      logic             frame;
   } exp_t;

   exp_t       sbq[$];
   exp_t       exp_now;
   int         m_sx, m_sy, m_cnt;
   logic [1:0] m_mode;
   int         n_checks = 0;
   int         n_errors = 0;

   function automatic exp_t model_pixel(input int x, input int y, input logic [1:0] md, input int cnt);
      exp_t p;
      int   bar;
      p       = '0;
      p.sx    = CORDW'(x);
      p.sy    = CORDW'(y);
      p.de    = (x < 16) && (y < 8);
      p.hsync = (x >= 18) && (x < 20);
      p.vsync = (y == 9);
      p.frame = (x == 0) && (y == 0);
      if (p.de) begin
         case (md)
            2'd0: begin
               bar = x / 2;
               p.r = bar[2] ? 8'hFF : 8'h00;
               p.g = bar[1] ? 8'hFF : 8'h00;
               p.b = bar[0] ? 8'hFF : 8'h00;
            end
            2'd1: if ((((x >> 4) ^ (y >> 4)) & 1) == 1) {p.r, p.g, p.b} = 24'hFFFFFF;
            2'd2: begin
               p.r = 8'(x);
               p.g = 8'(y);
               p.b = 8'(cnt);
            end
            default: {p.r, p.g, p.b} = ((x % 32) == 0 || (y % 32) == 0) ? 24'hFFFFFF : 24'h0000FF;
         endcase
      end
      return p;
   endfunction

   task automatic model_reset();
      m_sx   = 0;
      m_sy   = 0;
      m_cnt  = 0;
      m_mode = 2'd0;
      sbq.delete();
      for (int k = 0; k < PIPE - 1; k++) sbq.push_back('0);
   endtask

   // One pixel clock: model pushes its stage-0 pixel, the oldest one is popped and scored.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_pix);
         if (rst_pix_n) begin
            sbq.push_back(model_pixel(m_sx, m_sy, m_mode, m_cnt));
            exp_now = sbq.pop_front();
            if (m_sx == H_TOTAL - 1) begin
               m_sx = 0;
               if (m_sy == V_TOTAL - 1) begin
                  m_sy   = 0;
                  m_mode = mode;
                  if (!freeze) m_cnt = (m_cnt + 1) & 16'hFFFF;
               end else begin
                  m_sy++;
               end
            end else begin
               m_sx++;
            end
         end else begin
            exp_now = '0;
         end
         @(negedge clk_pix);
         n_checks++;
         if ({sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame} !== exp_now) begin
            n_errors++;
            $display("FAIL scoreboard @%0t got=%h expected=%h", $time,
                     {sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame}, exp_now);
         end
      end
   endtask

   task automatic wait_out(input int x, input int y, input int max_cyc, input string tag);
      int c = 0;
      do begin
         step(1);
         c++;
      end while (!(sdl_sx == CORDW'(x) && sdl_sy == CORDW'(y)) && c < max_cyc);
      if (!(sdl_sx == CORDW'(x) && sdl_sy == CORDW'(y))) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout got sx=%0d sy=%0d required sx=%0d sy=%0d", tag, sdl_sx, sdl_sy, x, y);
      end
   endtask

   task automatic test_reset();
      rst_pix_n = 1'b0;
      mode      = 2'd0;
      freeze    = 1'b0;
      repeat (3) @(negedge clk_pix);
      n_checks++;
      if ({sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs got=%h required=0",
                  {sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame});
      end
      n_checks++;
      if (frame_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_frame_cnt got=%h required=0000", frame_cnt);
      end
      model_reset();
      rst_pix_n = 1'b1;
      step(1);
      n_checks++;
      if (sdl_frame !== 1'b0 || sdl_de !== 1'b0) begin
         n_errors++;
         $display("FAIL first_cycle got frame=%b de=%b required frame=0 de=0", sdl_frame, sdl_de);
      end
      step(1);
      n_checks++;
      if (sdl_frame !== 1'b1 || sdl_sx !== '0 || sdl_sy !== '0 || sdl_de !== 1'b1 || frame_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL first_pixel got frame=%b sx=%0d sy=%0d de=%b cnt=%0d required 1 0 0 1 0",
                  sdl_frame, sdl_sx, sdl_sy, sdl_de, frame_cnt);
      end
   endtask

   task automatic test_timing();
      int                   de_cnt [V_TOTAL];
      logic [H_TOTAL-1:0]   hs_mask;
      logic [V_TOTAL-1:0]   vs_mask;
      int                   cyc;
      hs_mask = '0;
      vs_mask = '0;
      cyc     = 0;
      for (int y = 0; y < V_TOTAL; y++) de_cnt[y] = 0;
      do begin
         if (sdl_sy < CORDW'(V_TOTAL) && sdl_sx < CORDW'(H_TOTAL)) begin
            de_cnt[sdl_sy] += int'(sdl_de);
            if (sdl_hsync) hs_mask[sdl_sx] = 1'b1;
            if (sdl_vsync) vs_mask[sdl_sy] = 1'b1;
         end
         step(1);
         cyc++;
      end while (!sdl_frame && cyc < 1000);
      n_checks++;
      if (cyc != H_TOTAL * V_TOTAL) begin
         n_errors++;
         $display("FAIL frame_period got=%0d required=%0d", cyc, H_TOTAL * V_TOTAL);
      end
      for (int y = 0; y < V_TOTAL; y++) begin
         n_checks++;
         if (de_cnt[y] != ((y < 8) ? 16 : 0)) begin
            n_errors++;
            $display("FAIL de_per_line y=%0d got=%0d required=%0d", y, de_cnt[y], (y < 8) ? 16 : 0);
         end
      end
      n_checks++;
      if (hs_mask !== 24'h0C0000) begin
         n_errors++;
         $display("FAIL hsync_columns got=%h required=0c0000", hs_mask);
      end
      n_checks++;
      if (vs_mask !== 12'h200) begin
         n_errors++;
         $display("FAIL vsync_lines got=%h required=200", vs_mask);
      end
   endtask

   task automatic test_bars();
      int   xs   [4] = '{0, 2, 14, 17};
      logic [23:0] want [4] = '{24'h000000, 24'h0000FF, 24'hFFFFFF, 24'h000000};
      for (int k = 0; k < 4; k++) begin
         wait_out(xs[k], 1, 100, "bars_seek");
         n_checks++;
         if ({sdl_r, sdl_g, sdl_b} !== want[k]) begin
            n_errors++;
            $display("FAIL bars sx=%0d got=%h required=%h", xs[k], {sdl_r, sdl_g, sdl_b}, want[k]);
         end
      end
   endtask

   task automatic test_mode_switch();
      int base;
      wait_out(5, 3, 400, "switch_seek");
      mode = 2'd2;
      base = m_cnt;
      wait_out(14, 5, 400, "switch_same_frame");
      n_checks++;
      if ({sdl_r, sdl_g, sdl_b} !== 24'hFFFFFF) begin
         n_errors++;
         $display("FAIL mode_midframe got=%h required=ffffff", {sdl_r, sdl_g, sdl_b});
      end
      wait_out(0, 0, 400, "switch_next_frame");
      n_checks++;
      if (frame_cnt !== 16'(base + 1)) begin
         n_errors++;
         $display("FAIL frame_cnt_inc got=%0d required=%0d", frame_cnt, base + 1);
      end
      wait_out(3, 2, 400, "grad_seek");
      n_checks++;
      if ({sdl_r, sdl_g, sdl_b} !== {8'h03, 8'h02, 8'(base + 1)}) begin
         n_errors++;
         $display("FAIL grad got=%h required=%h", {sdl_r, sdl_g, sdl_b}, {8'h03, 8'h02, 8'(base + 1)});
      end
      freeze = 1'b1;
      wait_out(0, 0, 400, "freeze_frame");
      freeze = 1'b0;
      n_checks++;
      if (frame_cnt !== 16'(base + 1)) begin
         n_errors++;
         $display("FAIL freeze_hold got=%0d required=%0d", frame_cnt, base + 1);
      end
      wait_out(3, 2, 400, "freeze_grad_seek");
      n_checks++;
      if (sdl_b !== 8'(base + 1)) begin
         n_errors++;
         $display("FAIL freeze_blue got=%h required=%h", sdl_b, 8'(base + 1));
      end
      wait_out(0, 0, 400, "unfreeze_frame");
      wait_out(3, 2, 400, "unfreeze_grad_seek");
      n_checks++;
      if (sdl_b !== 8'(base + 2) || frame_cnt !== 16'(base + 2)) begin
         n_errors++;
         $display("FAIL unfreeze got b=%h cnt=%0d required b=%h cnt=%0d", sdl_b, frame_cnt, 8'(base + 2), base + 2);
      end
   endtask

   task automatic test_reset_mid();
      wait_out(10, 4, 400, "midreset_seek");
      rst_pix_n = 1'b0;
      #1;
      n_checks++;
      if ({sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame} !== '0 ||
          frame_cnt !== 16'd0 || {w_sx, w_r, w_frame_cnt} !== '0) begin
         n_errors++;
         $display("FAIL async_reset got=%h cnt=%h required all zero",
                  {sdl_sx, sdl_sy, sdl_de, sdl_hsync, sdl_vsync, sdl_r, sdl_g, sdl_b, sdl_frame}, frame_cnt);
      end
      repeat (2) @(negedge clk_pix);
      model_reset();
      rst_pix_n = 1'b1;
      step(2);
      n_checks++;
      if (sdl_frame !== 1'b1 || sdl_sx !== '0 || sdl_sy !== '0 || frame_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL restart got frame=%b sx=%0d sy=%0d cnt=%0d required 1 0 0 0",
                  sdl_frame, sdl_sx, sdl_sy, frame_cnt);
      end
      wait_out(2, 0, 100, "restart_bars_seek");
      n_checks++;
      if ({sdl_r, sdl_g, sdl_b} !== 24'h0000FF) begin
         n_errors++;
         $display("FAIL restart_bars got=%h required=0000ff", {sdl_r, sdl_g, sdl_b});
      end
      mode = 2'd0;
   endtask

   task automatic test_wide();
      int c = 0;
      while (!(w_sx == CORDW'(165) && w_sy == '0 && w_frame_cnt == 16'd1) && c < 10000) begin
         @(negedge clk_pix);
         c++;
      end
      n_checks++;
      if (w_sx !== CORDW'(165) || w_de !== 1'b1 || w_r !== 12'hA5A || w_g !== 12'h000 || w_b !== 12'h010) begin
         n_errors++;
         $display("FAIL wide_grad got sx=%0d de=%b r=%h g=%h b=%h required 165 1 a5a 000 010",
                  w_sx, w_de, w_r, w_g, w_b);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_bars();
      test_mode_switch();
      test_reset_mid();
      test_wide();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
